// File: rtl/adder_pkg.sv
// Shared types and helpers for the adder operand/result stage.
package adder_pkg;

  // Width of the parallel-prefix adder this stage wraps.
  localparam int unsigned ADD_W = 6;

  // One captured result, as held in the result FIFO.
  typedef struct packed {
    logic             ovf;
    logic             cout;
    logic [ADD_W-1:0] sum;
  } res_t;

  // Builds a result entry; saturation forces the sum to all-ones on carry-out.
  function automatic res_t make_res(input logic [ADD_W-1:0] sum, input logic cout,
                                    input logic sat);
    res_t r;
    r.cout = cout;
    r.ovf  = sat && cout;
    r.sum  = r.ovf ? {ADD_W{1'b1}} : sum;
    return r;
  endfunction

endpackage

// File: rtl/adder_res_fifo.sv
// First-word-fall-through result queue; head entry reads as zero when empty.
module adder_res_fifo
  import adder_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  res_t push_data,
  input  logic pop,
  output res_t head,
  output logic empty,
  output logic full
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  res_t            mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  // Qualify requests: pop of an empty queue is dropped, push at full needs a pop.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CntW'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = empty ? '0 : mem_q[rd_ptr_q];
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/adder_op_stage.sv
// Handshaked operand/result stage around an external combinational adder.
// Stage 1 registers operands onto the adder inputs; stage 2 captures the
// (optionally saturated) sum into a result FIFO feeding a valid/ready consumer.
module adder_op_stage
  import adder_pkg::*;
#(
  parameter int unsigned W     = ADD_W,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  input  logic             in_sat,
  output logic [W-1:0]     add_x,
  output logic [W-1:0]     add_y,
  input  logic [W-1:0]     add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_valid_q, s1_valid_d;
  logic             s1_sat_q;
  logic [W-1:0]     x_q, y_q;
  logic [CNT_W-1:0] op_count_q;
  logic             accept, push, pop, fifo_can_push;
  logic             fifo_full, fifo_empty;
  res_t             push_res, head_res;

  // Handshake decode; a pop in the same cycle frees a slot for a push at full.
  always_comb begin
    out_valid     = !fifo_empty;
    pop           = out_valid && out_ready;
    fifo_can_push = !fifo_full || pop;
    push          = s1_valid_q && fifo_can_push;
    in_ready      = !s1_valid_q || fifo_can_push;
    accept        = in_valid && in_ready;
    s1_valid_d    = accept ? 1'b1 : (push ? 1'b0 : s1_valid_q);
    push_res      = make_res(add_s, add_cout, s1_sat_q);
  end

  // Stage-1 operand register; holds add_x/add_y steady until the result is pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sat_q   <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        x_q      <= in_x;
        y_q      <= in_y;
        s1_sat_q <= in_sat;
      end
    end
  end

  // Completed-operation counter, wraps modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (push) begin
      op_count_q <= op_count_q + CNT_W'(1);
    end
  end

  adder_res_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_res),
    .pop      (pop),
    .head     (head_res),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Drive outputs from the stage register and FIFO head.
  always_comb begin
    add_x    = x_q;
    add_y    = y_q;
    out_sum  = head_res.sum;
    out_cout = head_res.cout;
    out_ovf  = head_res.ovf;
    op_count = op_count_q;
  end

endmodule

// File: tb/tb_adder_op_stage.sv
// Scoreboard bench for adder_op_stage with a behavioural adder in place of the
// prefix-adder instance. A second, narrow-counter instance shares the stimulus.
module tb_adder_op_stage;

  localparam int unsigned W = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_sat, out_ready;
  logic [W-1:0] in_x, in_y;
  logic         in_ready, out_valid, out_cout, out_ovf, add_cout;
  logic [W-1:0] add_x, add_y, add_s, out_sum;
  logic [15:0]  op_count;

  logic         w_in_ready, w_out_valid, w_out_cout, w_out_ovf, w_add_cout;
  logic [W-1:0] w_add_x, w_add_y, w_add_s, w_out_sum;
  logic [3:0]   w_op_count;

  always #5 clk = ~clk;

  assign {add_cout, add_s}     = {1'b0, add_x} + {1'b0, add_y};
  assign {w_add_cout, w_add_s} = {1'b0, w_add_x} + {1'b0, w_add_y};

  adder_op_stage #(.W(W), .DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_sat(in_sat), .add_x(add_x), .add_y(add_y),
    .add_s(add_s), .add_cout(add_cout), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .op_count(op_count)
  );

  adder_op_stage #(.W(W), .DEPTH(2), .CNT_W(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_x(in_x), .in_y(in_y), .in_sat(in_sat), .add_x(w_add_x), .add_y(w_add_y),
    .add_s(w_add_s), .add_cout(w_add_cout), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_sum(w_out_sum), .out_cout(w_out_cout), .out_ovf(w_out_ovf), .op_count(w_op_count)
  );

  int          total = 0;
  int          bad = 0;
  int          exp_ops = 0;
  int          stalls = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_head;

  typedef struct {
    logic [5:0] x;
    logic [5:0] y;
    logic       sat;
    logic [7:0] e;  // {ovf, cout, sum}
  } vec_t;

  vec_t vecs[9] = '{
    '{6'd5,  6'd9,  1'b0, 8'h0E},
    '{6'd63, 6'd1,  1'b0, 8'h40},
    '{6'd63, 6'd1,  1'b1, 8'hFF},
    '{6'd32, 6'd32, 1'b0, 8'h40},
    '{6'd32, 6'd31, 1'b1, 8'h3F},
    '{6'd40, 6'd30, 1'b1, 8'hFF},
    '{6'd0,  6'd0,  1'b1, 8'h00},
    '{6'd21, 6'd42, 1'b0, 8'h3F},
    '{6'd33, 6'd33, 1'b0, 8'h42}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [5:0] x, input logic [5:0] y,
                                       input logic sat);
    logic [6:0] s;
    logic       ovf;
    s   = {1'b0, x} + {1'b0, y};
    ovf = sat && s[6];
    return {ovf, s[6], ovf ? 6'h3F : s[5:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present one operand pair and wait (bounded) for it to be accepted.
  task automatic send(input logic [5:0] x, input logic [5:0] y, input logic sat,
                      input logic [7:0] e);
    int n;
    in_x = x; in_y = y; in_sat = sat; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #3;
      n++;
    end
    stalls += n;
    if (n == 50) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
    end else begin
      exp_q.push_back(e);
      exp_ops++;
    end
    tick();
  endtask

  // Monitor: every result taken by the consumer is compared with the queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %0h want none", {out_ovf, out_cout, out_sum});
      end else begin
        exp_head = exp_q.pop_front();
        check("result", {24'd0, out_ovf, out_cout, out_sum}, {24'd0, exp_head});
      end
    end
  end

  initial begin
    logic [5:0] rx, ry;
    logic       rs;
    int         base;

    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_sat = 1'b0; out_ready = 1'b1;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_op_count", op_count, 0);
    check("rst_add_x", add_x, 0);
    check("rst_add_y", add_y, 0);
    check("rst_out_sum", {out_ovf, out_cout, out_sum}, 0);
    @(posedge clk);
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Single op latency: accept edge N, push edge N+1.
    send(vecs[0].x, vecs[0].y, vecs[0].sat, vecs[0].e);
    in_valid = 1'b0;
    #1;
    check("lat_not_yet_valid", out_valid, 0);
    @(posedge clk);
    #3;
    check("lat_valid", out_valid, 1);
    check("lat_sum", out_sum, 14);
    check("lat_cout", out_cout, 0);
    check("lat_ovf", out_ovf, 0);
    tick();

    // Directed carry/saturation vectors, back to back.
    for (int i = 1; i < 9; i++) send(vecs[i].x, vecs[i].y, vecs[i].sat, vecs[i].e);
    in_valid = 1'b0;
    repeat (3) tick();
    check("directed_op_count", op_count, 32'(exp_ops));
    check("directed_drained", exp_q.size(), 0);

    // Streaming with the consumer always ready.
    base = exp_ops;
    stalls = 0;
    for (int i = 0; i < 32; i++) begin
      rx = 6'($urandom_range(0, 63));
      ry = 6'($urandom_range(0, 63));
      rs = 1'($urandom_range(0, 1));
      send(rx, ry, rs, model(rx, ry, rs));
    end
    in_valid = 1'b0;
    repeat (4) tick();
    check("stream_stalls", stalls, 0);
    check("stream_ops", 32'(op_count) - 32'(base), 32);
    check("stream_op_count", op_count, 32'(exp_ops));
    check("wrap_op_count", w_op_count, 32'(exp_ops % 16));
    check("stream_drained", exp_q.size(), 0);

    // Backpressure: two results fill the FIFO, a third waits in stage 1.
    out_ready = 1'b0;
    send(6'd10, 6'd20, 1'b0, 8'h1E);
    send(6'd50, 6'd20, 1'b0, 8'h46);
    send(6'd7,  6'd8,  1'b1, 8'h0F);
    in_x = 6'd60; in_y = 6'd60; in_sat = 1'b1; in_valid = 1'b1;
    #1;
    check("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check("bp_hold_ready", in_ready, 0);
      check("bp_hold_x", add_x, 7);
      check("bp_hold_y", add_y, 8);
      check("bp_head", out_sum, 30);
    end
    exp_q.push_back(8'hFF);
    exp_ops++;
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("bp_drained", exp_q.size(), 0);

    // Full FIFO with simultaneous push and pop every cycle.
    out_ready = 1'b0;
    send(6'd1, 6'd2, 1'b0, 8'h03);
    send(6'd3, 6'd4, 1'b0, 8'h07);
    in_valid = 1'b0;
    repeat (2) tick();
    #1;
    check("full_valid", out_valid, 1);
    out_ready = 1'b1;
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      rx = 6'(10 * i + 5);
      ry = 6'(7 * i);
      send(rx, ry, 1'b0, model(rx, ry, 1'b0));
      check("full_pp_valid", out_valid, 1);
    end
    check("full_pp_stalls", stalls, 0);
    in_valid = 1'b0;
    repeat (5) tick();
    check("full_pp_drained", exp_q.size(), 0);
    check("full_pp_op_count", op_count, 32'(exp_ops));
    check("full_pp_wrap", w_op_count, 32'(exp_ops % 16));

    // Reset asserted with operands and results in flight.
    out_ready = 1'b0;
    send(6'd11, 6'd12, 1'b0, 8'h17);
    send(6'd13, 6'd14, 1'b0, 8'h1B);
    in_x = 6'd15; in_y = 6'd16; in_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_op_count", op_count, 0);
    check("mid_rst_wrap_count", w_op_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_add_x", add_x, 0);
    check("mid_rst_add_y", add_y, 0);
    exp_q.delete();
    exp_ops = 0;
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("post_rst_empty", out_valid, 0);
    send(6'd5, 6'd9, 1'b0, 8'h0E);
    in_valid = 1'b0;
    repeat (4) tick();
    check("post_rst_op_count", op_count, 1);
    check("final_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
